fifo: RTL and testbench
=======================

# fifo

Synchronous single-clock first-in/first-out buffer with ready/enable handshakes on both the enqueue and dequeue sides. It decouples a word producer from a word consumer that share `i_clk`, for example between serial-communication front ends and their byte processors. Depth and word width are parameters. The read side is first-word-fall-through: the head word is visible before it is dequeued.

## Interface
Parameters:
- `p_WORD_LEN`, default 8: data word width in bits, ≥1.
- `p_FIFO_SIZE`, default 8: number of storage entries, ≥2; need not be a power of two.

Ports:
- `i_clk`, input, 1: the single clock; all state updates on its rising edge.
- `i_reset`, input, 1: asynchronous, active-low reset.
- `o_full`, output, 1: high when the stored count equals `p_FIFO_SIZE`.
- `o_empty`, output, 1: high when the stored count is 0.
- `i_enq_data`, input, `p_WORD_LEN`: word to enqueue.
- `i_enq_en`, input, 1: enqueue request.
- `o_enq_rdy`, output, 1: equals `!o_full`.
- `o_out_data`, output, `p_WORD_LEN`: current head word; 0 when empty.
- `i_deq_en`, input, 1: dequeue request, which pops the head.
- `o_deq_rdy`, output, 1: equals `!o_empty`.

## Operation
- State:
  - storage array of `p_FIFO_SIZE` words, not reset;
  - write pointer and read pointer, each 0..`p_FIFO_SIZE`-1;
  - count register, 0..`p_FIFO_SIZE`, width `$clog2(p_FIFO_SIZE+1)`.
- Enqueue fires when `i_enq_en && o_enq_rdy`:
  - write `i_enq_data` at the write pointer;
  - advance the write pointer.
- Dequeue fires when `i_deq_en && o_deq_rdy`:
  - advance the read pointer.
- Pointer advance: +1, wrapping from `p_FIFO_SIZE`-1 to 0 (explicit compare, not modulo-2^n).
- Count update:
  - +1 on enqueue only;
  - −1 on dequeue only;
  - unchanged when both fire or neither fires.
- Requests against a blocked side are ignored without error or state change:
  - enqueue while full;
  - dequeue while empty.
- Simultaneous enq and deq:
  - 0 < count < size: both fire; count unchanged; data order preserved.
  - Full: only the dequeue fires, because `o_enq_rdy` is low; count becomes size−1. The offered word is dropped, and the producer must hold it and retry.
  - Empty: only the enqueue fires; count becomes 1. The word is not available to the consumer until the next cycle (no bypass).
- Output derivation:
  - `o_out_data` = storage[read pointer] when count > 0, else 0;
  - `o_full`, `o_empty`, `o_enq_rdy` and `o_deq_rdy` are decoded combinationally from the count register only, never from the inputs.

## Timing
- Reset (`i_reset` = 0):
  - takes effect immediately, independent of `i_clk`;
  - pointers = 0, count = 0;
  - outputs: `o_empty` = 1, `o_full` = 0, `o_enq_rdy` = 1, `o_deq_rdy` = 0, `o_out_data` = 0.
- Reset mid-operation discards all stored words. The first enqueue after reset release is accepted on the first rising edge at which `i_reset` = 1.
- Enqueue latency:
  - the word is stored at the rising edge where the enqueue fires;
  - if the FIFO was empty, `o_out_data` shows the word and `o_deq_rdy` rises just after that edge.
- Dequeue: at the firing edge `o_out_data` advances to the next word, or goes to 0 if the FIFO becomes empty.
- Flag timing: `o_full` / `o_empty` change only after a clock edge or on reset, never combinationally from `i_enq_en` / `i_deq_en`.
- Throughput: one enqueue and one dequeue per cycle are sustainable.

## Test plan
- Reset then idle → `o_empty`=1, `o_full`=0, `o_enq_rdy`=1, `o_deq_rdy`=0, `o_out_data`=0.
- Fill (size 8): hold `i_enq_en`=1 with words 0x11..0x88, one per cycle.
  - `o_full`=1 after the 8th edge;
  - a 9th word 0x99 is ignored;
  - `o_out_data`=0x11.
- Drain the full FIFO with `i_deq_en`=1.
  - `o_out_data` steps 0x11, 0x22, …, 0x88;
  - `o_empty`=1 after the 8th edge;
  - a further dequeue leaves `o_empty`=1 and `o_out_data`=0.
- Wrap-around: fill 8, dequeue 3, enqueue 3 more (0xA1..0xA3), drain.
  - expected order: 0x44..0x88, then 0xA1, 0xA2, 0xA3;
  - count stays within bounds throughout.
- Simultaneous enq+deq:
  - count 4 → count remains 4, order preserved;
  - full → count becomes 7 and the offered word is not stored;
  - empty → count becomes 1.
- Reset asserted mid-operation with 5 words stored → immediate `o_empty`=1 and `o_out_data`=0. After release, a fresh fill/drain of 8 words returns them exactly in order.

Source files
------------

// File: rtl/fifo.sv
// Single-clock FIFO with ready/enable handshakes on both sides.
// The read side is first-word-fall-through, and the depth need not be a power of two.
module fifo #(
  parameter int p_WORD_LEN  = 8,
  parameter int p_FIFO_SIZE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic [p_WORD_LEN-1:0] i_enq_data,
  input  logic                  i_enq_en,
  output logic                  o_enq_rdy,
  output logic [p_WORD_LEN-1:0] o_out_data,
  input  logic                  i_deq_en,
  output logic                  o_deq_rdy
);

  localparam int CW = $clog2(p_FIFO_SIZE + 1);
  localparam int PW = (p_FIFO_SIZE > 1) ? $clog2(p_FIFO_SIZE) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(p_FIFO_SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(p_FIFO_SIZE);

  logic [p_WORD_LEN-1:0] mem [p_FIFO_SIZE];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  enq_fire;
  logic                  deq_fire;

  // Flags depend only on the count register, so they never follow the request inputs.
  always_comb begin
    o_full    = (count == FULL_CNT);
    o_empty   = (count == '0);
    o_enq_rdy = !o_full;
    o_deq_rdy = !o_empty;
    enq_fire  = i_enq_en && o_enq_rdy;
    deq_fire  = i_deq_en && o_deq_rdy;
  end

  always_comb begin
    o_out_data = '0;
    if (count != '0)
      o_out_data = mem[rd_ptr];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (deq_fire)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (enq_fire && !deq_fire)
        count <= count + 1'b1;
      else if (deq_fire && !enq_fire)
        count <= count - 1'b1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (enq_fire)
      mem[wr_ptr] <= i_enq_data;
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo.
// A queue-based reference model checks directed scenarios and random traffic.
module tb_fifo;

  localparam int W    = 8;
  localparam int SIZE = 8;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         o_full, o_empty, o_enq_rdy, o_deq_rdy;
  logic [W-1:0] i_enq_data = '0;
  logic         i_enq_en = 1'b0;
  logic [W-1:0] o_out_data;
  logic         i_deq_en = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [W-1:0] model_q [$];

  fifo #(.p_WORD_LEN(W), .p_FIFO_SIZE(SIZE)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .i_enq_data (i_enq_data),
    .i_enq_en   (i_enq_en),
    .o_enq_rdy  (o_enq_rdy),
    .o_out_data (o_out_data),
    .i_deq_en   (i_deq_en),
    .o_deq_rdy  (o_deq_rdy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned n = model_q.size();
    chk({tag, ":empty"}, 32'(o_empty),   32'(n == 0));
    chk({tag, ":full"},  32'(o_full),    32'(n == SIZE));
    chk({tag, ":enq_rdy"}, 32'(o_enq_rdy), 32'(n != SIZE));
    chk({tag, ":deq_rdy"}, 32'(o_deq_rdy), 32'(n != 0));
    chk({tag, ":data"},  32'(o_out_data), (n != 0) ? 32'(model_q[0]) : 32'd0);
  endtask

  // One cycle: drive the requests, confirm the outputs ignore them, clock, update the model, then check.
  task automatic step(input string tag, input logic enq, input logic [W-1:0] data, input logic deq);
    bit enq_ok, deq_ok;
    i_enq_en   = enq;
    i_enq_data = data;
    i_deq_en   = deq;
    #1;
    check_state({tag, ":pre"});
    enq_ok = enq && (model_q.size() < SIZE);
    deq_ok = deq && (model_q.size() > 0);
    @(posedge i_clk);
    if (deq_ok) void'(model_q.pop_front());
    if (enq_ok) model_q.push_back(data);
    #1;
    i_enq_en = 1'b0;
    i_deq_en = 1'b0;
    check_state(tag);
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, W'(i * 8'h11), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < SIZE + 1; i++) step("drain", 1'b0, '0, 1'b1);
  endtask

  initial begin
    #3;
    check_state("reset");
    @(posedge i_clk);
    #1;
    check_state("reset_idle");
    i_reset = 1'b1;

    // Fill to full, offer a ninth word, then drain past empty.
    fill8();
    chk("full_after_8", 32'(o_full), 32'd1);
    step("ninth", 1'b1, 8'h99, 1'b0);
    chk("head_after_fill", 32'(o_out_data), 32'h11);
    drain();
    chk("empty_after_drain", 32'(o_empty), 32'd1);

    // Wrap-around.
    fill8();
    for (int i = 0; i < 3; i++) step("wrap_deq", 1'b0, '0, 1'b1);
    for (int i = 1; i <= 3; i++) step("wrap_enq", 1'b1, W'(8'hA0 + i), 1'b0);
    chk("wrap_full", 32'(o_full), 32'd1);
    drain();

    // Simultaneous enq+deq when empty, at a count of 4, and when full.
    step("sim_empty", 1'b1, 8'h5A, 1'b1);
    chk("sim_empty_cnt1", 32'(model_q.size()), 32'd1);
    for (int i = 0; i < 3; i++) step("to4", 1'b1, W'(8'h60 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("sim_mid", 1'b1, W'(8'h70 + i), 1'b1);
    for (int i = 0; i < 4; i++) step("to_full", 1'b1, W'(8'h80 + i), 1'b0);
    step("sim_full", 1'b1, 8'hEE, 1'b1);
    chk("sim_full_notfull", 32'(o_full), 32'd0);
    drain();

    // Assert reset mid-operation with 5 words stored.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, W'(8'hC0 + i), 1'b0);
    #2;
    i_reset = 1'b0;
    model_q.delete();
    #1;
    check_state("async_rst");
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    fill8();
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int unsigned bias = (i / 100) % 2 == 0 ? 70 : 30;
      step("rand", ($urandom_range(99) < bias), W'($urandom), ($urandom_range(99) >= bias));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
